pc_sequencer: RTL and testbench

Control FSM that sequences the 10-bit program counter of the MCU. Each instruction is fetched and executed in two clock cycles, plus one extra cycle when an interrupt is taken. Each cycle the block drives the counter's reset, load and increment strobes, selects the counter's load source, and issues stack push/pop strobes for CALL/RET/interrupt. It sits between the instruction decoder (which supplies the instruction class and branch condition) and the PC/stack datapath.

---
 rtl/pc_seq_pkg.sv | 31 +++
 rtl/pc_sequencer.sv | 108 ++++++++++
 tb/tb_pc_sequencer.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/pc_seq_pkg.sv
// Shared types for the MCU program-counter sequencer.
// Instruction classes, FSM states and PC load-source selects.
package pc_seq_pkg;

  typedef enum logic [2:0] {
    CLS_ALU    = 3'd0,
    CLS_JMP    = 3'd1,
    CLS_BRANCH = 3'd2,
    CLS_CALL   = 3'd3,
    CLS_RET    = 3'd4,
    CLS_RETIE  = 3'd5,
    CLS_SEI    = 3'd6,
    CLS_CLI    = 3'd7
  } instr_class_t;

  typedef enum logic [1:0] {
    S_INIT  = 2'd0,
    S_FETCH = 2'd1,
    S_EXEC  = 2'd2,
    S_INTR  = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    SEL_IMM    = 2'd0,
    SEL_STACK  = 2'd1,
    SEL_VECTOR = 2'd2
  } pc_mux_sel_t;

  localparam logic [9:0] INTR_VECTOR_DEFAULT = 10'h3FF;

endpackage

// File: rtl/pc_sequencer.sv
// Two-cycle fetch/execute sequencer driving the PC and return stack.
// Interrupt entry adds one cycle that pushes the resume address.
module pc_sequencer
  import pc_seq_pkg::*;
(
  input  logic       CLK,
  input  logic       RST_N,
  input  logic [2:0] INSTR_CLASS,
  input  logic       COND_MET,
  input  logic       INTR,
  output logic       IR_LD,
  output logic       PC_RST,
  output logic       PC_LD,
  output logic       PC_INC,
  output logic [1:0] PC_MUX_SEL,
  output logic       STACK_PUSH,
  output logic       STACK_POP,
  output logic       IE
);

  state_t       state;
  state_t       state_nx;
  logic         ie_q;
  logic         ie_nx;
  logic         pend_q;
  logic         pend_nx;
  logic         pend_any;
  instr_class_t cls;
  pc_mux_sel_t  sel;

  assign cls        = instr_class_t'(INSTR_CLASS);
  assign pend_any   = pend_q | INTR;
  assign PC_MUX_SEL = sel;
  assign IE         = ie_q;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state  <= S_INIT;
      ie_q   <= 1'b0;
      pend_q <= 1'b0;
    end else begin
      state  <= state_nx;
      ie_q   <= ie_nx;
      pend_q <= pend_nx;
    end
  end

  always_comb begin
    state_nx   = state;
    ie_nx      = ie_q;
    pend_nx    = pend_any;
    IR_LD      = 1'b0;
    PC_RST     = 1'b0;
    PC_LD      = 1'b0;
    PC_INC     = 1'b0;
    STACK_PUSH = 1'b0;
    STACK_POP  = 1'b0;
    sel        = SEL_IMM;
    unique case (state)
      S_INIT: begin
        PC_RST   = 1'b1;
        ie_nx    = 1'b0;
        pend_nx  = 1'b0;
        state_nx = S_FETCH;
      end
      S_FETCH: begin
        IR_LD    = 1'b1;
        PC_INC   = 1'b1;
        state_nx = S_EXEC;
      end
      S_EXEC: begin
        unique case (cls)
          CLS_ALU: ;
          CLS_JMP: PC_LD = 1'b1;
          CLS_BRANCH: PC_LD = COND_MET;
          CLS_CALL: begin
            STACK_PUSH = 1'b1;
            PC_LD      = 1'b1;
          end
          CLS_RET: begin
            STACK_POP = 1'b1;
            PC_LD     = 1'b1;
            sel       = SEL_STACK;
          end
          CLS_RETIE: begin
            STACK_POP = 1'b1;
            PC_LD     = 1'b1;
            sel       = SEL_STACK;
            ie_nx     = 1'b1;
          end
          CLS_SEI: ie_nx = 1'b1;
          CLS_CLI: ie_nx = 1'b0;
        endcase
        // Uses the post-update IE so RETIE/SEI can enter at once.
        state_nx = (pend_any && ie_nx) ? S_INTR : S_FETCH;
      end
      S_INTR: begin
        STACK_PUSH = 1'b1;
        PC_LD      = 1'b1;
        sel        = SEL_VECTOR;
        ie_nx      = 1'b0;
        pend_nx    = INTR;
        state_nx   = S_FETCH;
      end
    endcase
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Vector-table bench for pc_sequencer with an attached PC/stack model.
// Expected strobes queue up per drive and are compared after settling.
module tb_pc_sequencer;
  import pc_seq_pkg::*;

  logic       CLK = 1'b0;
  logic       RST_N = 1'b0;
  logic [2:0] INSTR_CLASS = 3'd0;
  logic       COND_MET = 1'b0;
  logic       INTR = 1'b0;
  logic       IR_LD, PC_RST, PC_LD, PC_INC;
  logic [1:0] PC_MUX_SEL;
  logic       STACK_PUSH, STACK_POP, IE;

  always #5 CLK = ~CLK;

  pc_sequencer dut (
    .CLK(CLK), .RST_N(RST_N), .INSTR_CLASS(INSTR_CLASS),
    .COND_MET(COND_MET), .INTR(INTR), .IR_LD(IR_LD),
    .PC_RST(PC_RST), .PC_LD(PC_LD), .PC_INC(PC_INC),
    .PC_MUX_SEL(PC_MUX_SEL), .STACK_PUSH(STACK_PUSH),
    .STACK_POP(STACK_POP), .IE(IE)
  );

  typedef struct {
    instr_class_t cls;
    logic         cond;
    logic         intr;
    logic [9:0]   imm;
    logic [8:0]   out;
    logic         chk_pc;
    logic [9:0]   pc;
  } vec_t;

  vec_t tv[$];
  vec_t exp_q[$];
  int   errs = 0;
  int   checks = 0;
  int   split;

  // PC and return stack as the datapath would hold them
  logic [9:0] pc = 10'h155;
  logic [9:0] imm = 10'h000;
  logic [9:0] stk [16];
  logic [3:0] sp = 4'd0;

  always @(posedge CLK) begin
    if (PC_RST) pc <= 10'h000;
    else if (PC_LD)
      pc <= (PC_MUX_SEL == 2'd0) ? imm :
            (PC_MUX_SEL == 2'd1) ? stk[sp - 4'd1] :
            INTR_VECTOR_DEFAULT;
    else if (PC_INC) pc <= pc + 10'd1;
    if (STACK_PUSH) begin
      stk[sp] <= pc;
      sp <= sp + 4'd1;
    end else if (STACK_POP) begin
      sp <= sp - 4'd1;
    end
  end

  function automatic logic [8:0] o(
    input logic ir, rst, ld, inc,
    input logic [1:0] sel,
    input logic push, pop, ie);
    return {ir, rst, ld, inc, sel, push, pop, ie};
  endfunction

  function automatic logic [8:0] o_init();
    return o(0, 1, 0, 0, 2'd0, 0, 0, 0);
  endfunction
  function automatic logic [8:0] o_fetch(input logic ie);
    return o(1, 0, 0, 1, 2'd0, 0, 0, ie);
  endfunction
  function automatic logic [8:0] o_idle(input logic ie);
    return o(0, 0, 0, 0, 2'd0, 0, 0, ie);
  endfunction
  function automatic logic [8:0] o_jmp(input logic ie);
    return o(0, 0, 1, 0, 2'd0, 0, 0, ie);
  endfunction
  function automatic logic [8:0] o_call(input logic ie);
    return o(0, 0, 1, 0, 2'd0, 1, 0, ie);
  endfunction
  function automatic logic [8:0] o_ret(input logic ie);
    return o(0, 0, 1, 0, 2'd1, 0, 1, ie);
  endfunction
  function automatic logic [8:0] o_vec(input logic ie);
    return o(0, 0, 1, 0, 2'd2, 1, 0, ie);
  endfunction

  task automatic add(input instr_class_t cls,
                     input logic cond, input logic intr,
                     input logic [9:0] im, input logic [8:0] out,
                     input logic chk, input logic [9:0] p);
    vec_t v;
    v.cls = cls; v.cond = cond; v.intr = intr; v.imm = im;
    v.out = out; v.chk_pc = chk; v.pc = p;
    tv.push_back(v);
  endtask

  task automatic check_out(input string name);
    vec_t e;
    logic [8:0] act;
    e = exp_q.pop_front();
    act = {IR_LD, PC_RST, PC_LD, PC_INC, PC_MUX_SEL,
           STACK_PUSH, STACK_POP, IE};
    checks++;
    if (act !== e.out) begin
      errs++;
      $display("FAIL %s strobes: got %b want %b", name, act, e.out);
    end
    if (e.chk_pc) begin
      checks++;
      if (pc !== e.pc) begin
        errs++;
        $display("FAIL %s pc: got %h want %h", name, pc, e.pc);
      end
    end
    checks++;
    if (!$onehot0({PC_RST, PC_LD, PC_INC}) ||
        (STACK_PUSH && STACK_POP) ||
        (!PC_LD && PC_MUX_SEL != 2'd0)) begin
      errs++;
      $display("FAIL %s exclusivity: rst/ld/inc=%b%b%b push/pop=%b%b sel=%0d",
               name, PC_RST, PC_LD, PC_INC, STACK_PUSH, STACK_POP,
               PC_MUX_SEL);
    end
  endtask

  task automatic expect_now(input logic [8:0] out, input logic chk,
                            input logic [9:0] p, input string name);
    vec_t v;
    v.cls = CLS_ALU; v.cond = 0; v.intr = INTR; v.imm = imm;
    v.out = out; v.chk_pc = chk; v.pc = p;
    exp_q.push_back(v);
    check_out(name);
  endtask

  task automatic apply(input int i);
    @(negedge CLK);
    RST_N       = 1'b1;
    INSTR_CLASS = tv[i].cls;
    COND_MET    = tv[i].cond;
    INTR        = tv[i].intr;
    imm         = tv[i].imm;
    exp_q.push_back(tv[i]);
    #1 check_out($sformatf("row%0d", i));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // ALU x3 from reset, PC reads 0,1,2,3
    add(CLS_ALU,    0, 0, 10'h000, o_init(),     0, 10'h000); // 0
    add(CLS_ALU,    0, 0, 10'h000, o_fetch(0),   1, 10'h000);
    add(CLS_ALU,    0, 0, 10'h000, o_idle(0),    1, 10'h001);
    add(CLS_ALU,    0, 0, 10'h000, o_fetch(0),   1, 10'h001);
    add(CLS_ALU,    0, 0, 10'h000, o_idle(0),    1, 10'h002);
    add(CLS_ALU,    0, 0, 10'h000, o_fetch(0),   1, 10'h002);
    add(CLS_ALU,    0, 0, 10'h000, o_idle(0),    1, 10'h003);
    add(CLS_ALU,    0, 0, 10'h000, o_fetch(0),   1, 10'h003);
    // JMP 0x020, BRANCH not taken, BRANCH taken
    add(CLS_JMP,    0, 0, 10'h020, o_jmp(0),     1, 10'h004); // 8
    add(CLS_ALU,    0, 0, 10'h000, o_fetch(0),   1, 10'h020);
    add(CLS_BRANCH, 0, 0, 10'h080, o_idle(0),    1, 10'h021);
    add(CLS_ALU,    0, 0, 10'h000, o_fetch(0),   1, 10'h021);
    add(CLS_BRANCH, 1, 0, 10'h040, o_jmp(0),     1, 10'h022);
    add(CLS_ALU,    0, 0, 10'h000, o_fetch(0),   1, 10'h040);
    // CALL 0x100 then RET
    add(CLS_CALL,   0, 0, 10'h100, o_call(0),    1, 10'h041); // 14
    add(CLS_ALU,    0, 0, 10'h000, o_fetch(0),   1, 10'h100);
    add(CLS_RET,    0, 0, 10'h000, o_ret(0),     1, 10'h101);
    add(CLS_ALU,    0, 0, 10'h000, o_fetch(0),   1, 10'h041);
    // SEI, INTR during next EXEC, entry to vector
    add(CLS_SEI,    0, 0, 10'h000, o_idle(0),    1, 10'h042); // 18
    add(CLS_ALU,    0, 0, 10'h000, o_fetch(1),   1, 10'h042);
    add(CLS_ALU,    0, 1, 10'h000, o_idle(1),    1, 10'h043);
    add(CLS_ALU,    0, 0, 10'h000, o_vec(1),     1, 10'h043);
    add(CLS_ALU,    0, 0, 10'h000, o_fetch(0),   1, 10'h3FF);
    // CLI, INTR while disabled, held over 5 instructions
    add(CLS_CLI,    0, 0, 10'h000, o_idle(0),    1, 10'h000); // 23
    add(CLS_ALU,    0, 1, 10'h000, o_fetch(0),   1, 10'h000);
    add(CLS_ALU,    0, 0, 10'h000, o_idle(0),    1, 10'h001);
    add(CLS_ALU,    0, 0, 10'h000, o_fetch(0),   1, 10'h001);
    add(CLS_ALU,    0, 0, 10'h000, o_idle(0),    1, 10'h002);
    add(CLS_ALU,    0, 0, 10'h000, o_fetch(0),   1, 10'h002);
    add(CLS_CLI,    0, 0, 10'h000, o_idle(0),    1, 10'h003);
    add(CLS_ALU,    0, 0, 10'h000, o_fetch(0),   1, 10'h003);
    add(CLS_ALU,    0, 0, 10'h000, o_idle(0),    1, 10'h004);
    add(CLS_ALU,    0, 0, 10'h000, o_fetch(0),   1, 10'h004);
    add(CLS_ALU,    0, 0, 10'h000, o_idle(0),    1, 10'h005);
    add(CLS_ALU,    0, 0, 10'h000, o_fetch(0),   1, 10'h005);
    // RETIE with pending enters INTR directly; INTR in INTR re-arms
    add(CLS_RETIE,  0, 0, 10'h000, o_ret(0),     1, 10'h006); // 35
    add(CLS_ALU,    0, 1, 10'h000, o_vec(1),     1, 10'h043);
    add(CLS_ALU,    0, 0, 10'h000, o_fetch(0),   1, 10'h3FF);
    add(CLS_SEI,    0, 0, 10'h000, o_idle(0),    1, 10'h000);
    add(CLS_ALU,    0, 0, 10'h000, o_vec(1),     1, 10'h000);
    add(CLS_ALU,    0, 0, 10'h000, o_fetch(0),   1, 10'h3FF);
    // Reach INTR once more for the mid-entry reset
    add(CLS_SEI,    0, 0, 10'h000, o_idle(0),    1, 10'h000); // 41
    add(CLS_ALU,    0, 0, 10'h000, o_fetch(1),   1, 10'h000);
    add(CLS_ALU,    0, 1, 10'h000, o_idle(1),    1, 10'h001);
    add(CLS_ALU,    0, 0, 10'h000, o_vec(1),     1, 10'h001);
    split = tv.size();
    // After reset: INTR during reset/INIT must not leave pending
    add(CLS_ALU,    0, 1, 10'h000, o_init(),     1, 10'h000);
    add(CLS_ALU,    0, 0, 10'h000, o_fetch(0),   1, 10'h000);
    add(CLS_SEI,    0, 0, 10'h000, o_idle(0),    1, 10'h001);
    add(CLS_ALU,    0, 0, 10'h000, o_fetch(1),   1, 10'h001);
    add(CLS_ALU,    0, 0, 10'h000, o_idle(1),    1, 10'h002);
    add(CLS_ALU,    0, 0, 10'h000, o_fetch(1),   1, 10'h002);
    add(CLS_CLI,    0, 0, 10'h000, o_idle(1),    1, 10'h003);

    // Held in reset
    @(negedge CLK);
    #1 expect_now(o_init(), 0, 10'h000, "reset_a");
    @(negedge CLK);
    #1 expect_now(o_init(), 1, 10'h000, "reset_b");

    for (int i = 0; i < split; i++) apply(i);

    // Asynchronous reset in the middle of INTR state
    #2;
    RST_N = 1'b0;
    INTR  = 1'b1;
    #1 expect_now(o_init(), 0, 10'h000, "async_rst");
    @(negedge CLK);
    #1 expect_now(o_init(), 1, 10'h000, "rst_hold");

    for (int i = split; i < tv.size(); i++) apply(i);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
